// File: rtl/imem_responder_pkg.sv
// Shared constants and state encoding for the instruction-memory responder.
package imem_responder_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam int          CNT_W     = 4;

    typedef enum logic [1:0] {
        IMEM_IDLE = 2'd0,
        IMEM_BUSY = 2'd1,
        IMEM_DONE = 2'd2
    } imem_state_t;

endpackage

// File: rtl/imem_sram_1r1w.sv
// Instruction array: one synchronous loader write port, one write-first read port.
module imem_sram_1r1w #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned DEPTH_LOG2 = 10
) (
    input  logic                  i_clk,
    input  logic                  i_we,
    input  logic [DEPTH_LOG2-1:0] i_waddr,
    input  logic [WIDTH-1:0]      i_wdata,
    input  logic [DEPTH_LOG2-1:0] i_raddr,
    output logic [WIDTH-1:0]      o_rdata
);

    logic [WIDTH-1:0] mem [2**DEPTH_LOG2];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            mem[i_waddr] <= i_wdata;
        end
    end

    // Bypass makes a write on the same edge visible to whatever registers o_rdata.
    assign o_rdata = (i_we && (i_waddr == i_raddr)) ? i_wdata : mem[i_raddr];

endmodule

// File: rtl/imem_responder.sv
// Fetch-side instruction memory: holds the IF address, inserts wait states, stalls the PC.
module imem_responder
    import imem_responder_pkg::*;
#(
    parameter int unsigned      WIDTH       = 32,
    parameter int unsigned      DEPTH_LOG2  = 10,
    parameter int unsigned      WAIT_STATES = 1,
    parameter logic [WIDTH-1:0] BASE_ADDR   = '0
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_req,
    input  logic [WIDTH-1:0]      i_instr_add,
    output logic [WIDTH-1:0]      o_instr,
    output logic                  o_instr_valid,
    output logic                  o_if_stall,
    output logic                  o_fault,
    input  logic                  i_ld_we,
    input  logic [DEPTH_LOG2-1:0] i_ld_addr,
    input  logic [WIDTH-1:0]      i_ld_data
);

    imem_state_t           state_q, state_d;
    logic [WIDTH-1:0]      addr_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [WIDTH-1:0]      offset_q;
    logic [DEPTH_LOG2-1:0] rd_idx;
    logic [WIDTH-1:0]      rd_data;
    logic                  addr_match;
    logic                  misalign;
    logic                  out_of_range;
    logic                  fault_now;
    logic                  ld_hit;
    logic                  load_fetch;
    logic                  cnt_dec;
    logic                  respond;

    // Address decode of the held fetch address.
    assign offset_q     = addr_q - BASE_ADDR;
    assign rd_idx       = offset_q[DEPTH_LOG2+1:2];
    assign misalign     = |addr_q[1:0];
    assign out_of_range = |(offset_q >> (DEPTH_LOG2 + 2));
    assign fault_now    = misalign | out_of_range;
    assign addr_match   = (i_instr_add == addr_q);
    assign ld_hit       = i_ld_we && (i_ld_addr == rd_idx) && !o_fault;

    imem_sram_1r1w #(
        .WIDTH      (WIDTH),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_sram (
        .i_clk   (i_clk),
        .i_we    (i_ld_we),
        .i_waddr (i_ld_addr),
        .i_wdata (i_ld_data),
        .i_raddr (rd_idx),
        .o_rdata (rd_data)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IMEM_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IMEM_IDLE: begin
                if (i_req && !i_ld_we) begin
                    state_d = IMEM_BUSY;
                end
            end
            IMEM_BUSY: begin
                if (!i_req || !addr_match) begin
                    state_d = IMEM_IDLE;
                end else if (!i_ld_we && (cnt_q == '0)) begin
                    state_d = IMEM_DONE;
                end
            end
            IMEM_DONE: begin
                if (ld_hit || !i_req) begin
                    state_d = IMEM_IDLE;
                end else if (!addr_match) begin
                    // A new address is accepted straight from DONE unless the loader owns this cycle.
                    state_d = i_ld_we ? IMEM_IDLE : IMEM_BUSY;
                end
            end
            default: state_d = IMEM_IDLE;
        endcase
    end

    always_comb begin
        o_if_stall = 1'b0;
        case (state_q)
            IMEM_IDLE: o_if_stall = i_req;
            IMEM_BUSY: o_if_stall = 1'b1;
            IMEM_DONE: o_if_stall = i_req && !addr_match;
            default:   o_if_stall = 1'b0;
        endcase
    end

    assign load_fetch = (state_d == IMEM_BUSY) && (state_q != IMEM_BUSY);
    assign cnt_dec    = (state_q == IMEM_BUSY) && (state_d == IMEM_BUSY) && !i_ld_we;
    assign respond    = (state_q == IMEM_BUSY) && (state_d == IMEM_DONE);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            addr_q        <= '0;
            cnt_q         <= '0;
            o_instr       <= '0;
            o_instr_valid <= 1'b0;
            o_fault       <= 1'b0;
        end else begin
            if (load_fetch) begin
                addr_q <= i_instr_add;
                cnt_q  <= CNT_W'(WAIT_STATES);
            end else if (cnt_dec && (cnt_q != '0)) begin
                cnt_q <= cnt_q - CNT_W'(1);
            end
            if (respond) begin
                o_instr <= fault_now ? WIDTH'(NOP_INSTR) : rd_data;
                o_fault <= fault_now;
            end
            o_instr_valid <= (state_d == IMEM_DONE);
        end
    end

endmodule

// File: doc/imem_responder.md
Name: imem_responder

Overview:
- Instruction-memory responder serving the fetch stage. It accepts the word address driven by the IF stage and returns the 32-bit instruction after a configurable number of wait states.
- While the word is not yet available it drives a stall back to the PC/IF pipe.
- Includes a boot-loader write port for program load and a fault flag for misaligned or out-of-range fetches.

Parameters:
- WIDTH, 32, instruction and address width.
- DEPTH_LOG2, 10, log2 of memory depth in 32-bit words (1024 words).
- WAIT_STATES, 1, extra BUSY cycles per fetch (0..15).
- BASE_ADDR, 32'h0000_0000, byte address mapped to word 0.

Ports:
- i_clk  in  1  clock; all logic on rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_req  in  1  fetch request; address valid.
- i_instr_add  in  WIDTH  byte fetch address (PC).
- o_instr  out  WIDTH  returned instruction; registered.
- o_instr_valid  out  1  o_instr corresponds to the held address this cycle.
- o_if_stall  out  1  1 = hold PC and IF/ID pipe.
- o_fault  out  1  misaligned or out-of-range fetch; valid with o_instr_valid.
- i_ld_we  in  1  loader write strobe.
- i_ld_addr  in  DEPTH_LOG2  loader word index.
- i_ld_data  in  WIDTH  loader write data.

Behaviour:
- Reset (i_rst=1 at an edge):
  - State goes to IDLE.
  - o_instr=0, o_instr_valid=0, o_fault=0, wait counter=0, addr_q=0.
  - Memory array is not cleared.
  - A reset asserted mid-fetch aborts the fetch with no response.
- States are IDLE, BUSY, DONE. addr_q is the held fetch address; cnt is the 4-bit wait counter.
- o_if_stall is combinational:
  - In IDLE: o_if_stall = i_req.
  - In BUSY: 1.
  - In DONE: 1 if i_req and i_instr_add != addr_q, else 0.
- IDLE:
  - If i_req=1 and i_ld_we=0: addr_q<=i_instr_add, cnt<=WAIT_STATES, go to BUSY.
  - If i_ld_we=1: loader has priority; remain in IDLE.
- BUSY:
  - If i_instr_add != addr_q or i_req=0 (redirect or cancel): go to IDLE with no response.
  - Else if i_ld_we=1: cnt is frozen.
  - Else if cnt!=0: cnt<=cnt-1.
  - Else (cnt==0): register the response, set o_instr_valid<=1, go to DONE.
- DONE:
  - o_instr_valid=1; the IF pipe captures o_instr on the edge where stall=0.
  - If i_req and address==addr_q: hold DONE (repeat hit, no stall).
  - If i_req and address differs: behave as IDLE acceptance in the same cycle (latch, go to BUSY, o_instr_valid<=0).
  - If i_req=0: go to IDLE, o_instr_valid<=0.
- Latency:
  - Request first seen in IDLE at cycle N gives DONE/valid at cycle N+WAIT_STATES+2.
  - Stall is high for cycles N..N+WAIT_STATES+1.
- Address mapping: word = (i_instr_add - BASE_ADDR) >> 2, 32-bit modular subtraction.
- Fault cases:
  - addr_q[1:0]!=0 → misaligned.
  - Word index >= 2^DEPTH_LOG2 → out of range.
  - On either: o_instr<=32'h0000_0013 (NOP), o_fault<=1. No array read is required.
  - Otherwise o_fault<=0.
- Loader:
  - Write commits at the edge where i_ld_we=1, in any state.
  - A fetch response registered after that edge returns the new data (read-after-write).
  - Write to addr_q's word while in DONE: invalidate, o_instr_valid<=0, go to IDLE.
- Simultaneous reset and loader write: reset wins for control state; whether the array write happens is don't-care.

Decomposition:
- Shared header (parameters.vh): NOP_INSTR=32'h0000_0013, state encodings IMEM_IDLE=2'd0, IMEM_BUSY=2'd1, IMEM_DONE=2'd2, WAIT_STATES width.
- One sub-module, imem_sram_1r1w:
  - Array of 2^DEPTH_LOG2 x WIDTH.
  - One synchronous write port (loader).
  - One read port with write-first semantics.
  - No reset.

Test Plan:
- Reset and single fetch, WAIT_STATES=1:
  - Stimulus: load word 0=32'h0050_0093; reset; i_req=1, addr=0 at cycle N.
  - Expected: stall high N..N+2; at N+3 o_instr=32'h0050_0093, valid=1, stall=0, fault=0.
- Sequential fetch:
  - Stimulus: addresses 0x0, then 0x4 (word 1=32'h00A0_0113) presented after DONE.
  - Expected: second response arrives WAIT_STATES+2 cycles after the address change. Each DONE cycle has stall=0 exactly once per address.
- Misaligned and out-of-range:
  - Stimulus: addr=0x2, then addr=0x1000 (DEPTH_LOG2=10).
  - Expected: each returns o_instr=32'h0000_0013 with o_fault=1.
- Redirect mid-BUSY:
  - Stimulus: addr 0x8 accepted; in the first BUSY cycle change to 0x40.
  - Expected: no response for 0x8; 0x40 data returned 1+WAIT_STATES+2 cycles after the change.
- Loader priority and invalidate:
  - Stimulus: i_ld_we held for 3 cycles during BUSY.
  - Expected: latency extends by 3 cycles. A loader write to the held word while in DONE drops valid and refetches, returning the new data.
- Reset mid-fetch:
  - Stimulus: assert i_rst in BUSY.
  - Expected: the next cycle has all outputs 0 and state IDLE. The array keeps its contents: a re-fetch returns the pre-reset data.
